// File: rtl/logic_unit_arbiter_if.sv
// Request/response bundle between two requesters, the logic-unit arbiter and the response consumer.
interface logic_unit_arbiter_if #(
    parameter int unsigned WIDTH = 4
);
    logic             req0_valid;
    logic [2:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;
    logic             req0_ready;

    logic             req1_valid;
    logic [2:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;
    logic             req1_ready;

    logic             rsp_valid;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_y;
    logic             rsp_err;
    logic             rsp_ready;

    logic             busy;

    // Requester/consumer side
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        input  req0_ready,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req1_ready,
        input  rsp_valid, rsp_id, rsp_y, rsp_err,
        output rsp_ready,
        input  busy
    );

    // Arbiter side
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        output req0_ready,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req1_ready,
        output rsp_valid, rsp_id, rsp_y, rsp_err,
        input  rsp_ready,
        output busy
    );
endinterface

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one bitwise logic unit (AND/OR/XOR/NAND/NOR) between two requesters.
module logic_unit_arbiter #(
    parameter int unsigned WIDTH = 4
) (
    input logic                  clk,
    input logic                  reset,
    logic_unit_arbiter_if.slave  bus
);
    localparam int unsigned OPW = 3;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [OPW-1:0] OP_AND  = 3'd0;
    localparam logic [OPW-1:0] OP_OR   = 3'd1;
    localparam logic [OPW-1:0] OP_XOR  = 3'd2;
    localparam logic [OPW-1:0] OP_NAND = 3'd3;
    localparam logic [OPW-1:0] OP_NOR  = 3'd4;

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic             last_grant;
    logic             grant_c;
    logic             accept_c;
    logic [OPW-1:0]   op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             id_q;
    logic [WIDTH-1:0] y_c;
    logic             err_c;

    // Pick a requester: a lone valid wins, a tie goes to the one not granted last
    always_comb begin
        grant_c = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_c = ~last_grant;
        end else if (bus.req1_valid) begin
            grant_c = 1'b1;
        end
    end

    assign bus.req0_ready = (state == IDLE) && !grant_c && bus.req0_valid;
    assign bus.req1_ready = (state == IDLE) &&  grant_c && bus.req1_valid;
    assign accept_c       = bus.req0_ready || bus.req1_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept -> one compute cycle -> hold response until taken
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_c) state_next = EXEC;
            EXEC:    state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Capture the granted operation and remember who won
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            id_q       <= 1'b0;
        end else if (accept_c) begin
            last_grant <= grant_c;
            id_q       <= grant_c;
            op_q       <= grant_c ? bus.req1_op : bus.req0_op;
            a_q        <= grant_c ? bus.req1_a  : bus.req0_a;
            b_q        <= grant_c ? bus.req1_b  : bus.req0_b;
        end
    end

    // Shared bitwise logic unit; unknown opcodes yield zero with an error flag
    always_comb begin
        y_c   = '0;
        err_c = 1'b0;
        case (op_q)
            OP_AND:  y_c = a_q & b_q;
            OP_OR:   y_c = a_q | b_q;
            OP_XOR:  y_c = a_q ^ b_q;
            OP_NAND: y_c = ~(a_q & b_q);
            OP_NOR:  y_c = ~(a_q | b_q);
            default: err_c = 1'b1;
        endcase
    end

    // Response registers: load in EXEC, hold through RESP until consumed
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_id    <= 1'b0;
            bus.rsp_y     <= '0;
            bus.rsp_err   <= 1'b0;
        end else if (state == EXEC) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= id_q;
            bus.rsp_y     <= y_c;
            bus.rsp_err   <= err_c;
        end else if ((state == RESP) && bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
        end
    end

    // Busy tracks the non-IDLE states as a registered flag
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.busy <= 1'b0;
        end else begin
            bus.busy <= (state_next != IDLE);
        end
    end
endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Scoreboard bench for logic_unit_arbiter: stimulus pushes expected responses, a monitor pops on each response handshake.
module tb_logic_unit_arbiter;
    typedef struct packed {
        logic       id;
        logic [3:0] y;
        logic       err;
    } exp_t;

    logic clk;
    logic reset;
    int   tests;
    int   fails;
    exp_t exp_q[$];

    logic_unit_arbiter_if #(.WIDTH(4)) bus ();

    logic_unit_arbiter #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        e.id  = id;
        e.err = 1'b0;
        case (op)
            3'd0:    e.y = a & b;
            3'd1:    e.y = a | b;
            3'd2:    e.y = a ^ b;
            3'd3:    e.y = ~(a & b);
            3'd4:    e.y = ~(a | b);
            default: begin e.y = 4'h0; e.err = 1'b1; end
        endcase
        return e;
    endfunction

    // Monitor: protocol sanity every cycle, scoreboard pop on each response handshake
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (bus.req0_ready && !bus.req0_valid) chk("ready0_without_valid", 1, 0);
            if (bus.req1_ready && !bus.req1_valid) chk("ready1_without_valid", 1, 0);
            if (bus.req0_ready && bus.req1_ready)  chk("both_ready", 1, 0);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_id",  32'(bus.rsp_id),  32'(e.id));
                    chk("rsp_y",   32'(bus.rsp_y),   32'(e.y));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
    endtask

    task automatic drive(input bit id, input logic v, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        if (id == 1'b0) begin
            bus.req0_valid = v; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = v; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
    endtask

    // Present one request, wait (bounded) for acceptance, log the expected response
    task automatic issue(input bit id, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        bit got;
        got = 1'b0;
        drive(id, 1'b1, op, a, b);
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = id ? bus.req1_ready : bus.req0_ready;
        end
        chk("issue_accept", 32'(got), 32'd1);
        if (got) exp_q.push_back(model(id, op, a, b));
        @(posedge clk); #1;
        if (id == 1'b0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
    endtask

    // Wait (bounded) until every expected response has been consumed and the DUT is idle
    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(posedge clk); #1;
            done = (exp_q.size() == 0) && !bus.busy && !bus.rsp_valid;
        end
        chk("drain", 32'(done), 32'd1);
    endtask

    initial begin
        int n_acc;
        int last_cyc;
        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 4'h0, 4'h0);
        drive(1'b1, 1'b0, 3'd0, 4'h0, 4'h0);
        tests = 0;
        fails = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("reset_busy",      32'(bus.busy),      0);
        chk("reset_rsp_y",     32'(bus.rsp_y),     0);
        chk("reset_rsp_id",    32'(bus.rsp_id),    0);
        chk("reset_rsp_err",   32'(bus.rsp_err),   0);

        // First op: AND, with latency checks
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 3'd0, 4'hC, 4'hA);
        @(negedge clk);
        chk("t1_ready0", 32'(bus.req0_ready), 1);
        exp_q.push_back('{id: 1'b0, y: 4'h8, err: 1'b0});
        @(posedge clk); #1 bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("t1_exec_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("t1_exec_busy",      32'(bus.busy),      1);
        @(negedge clk);
        chk("t1_t2_rsp_valid",   32'(bus.rsp_valid), 1);
        wait_drain();

        // Continuous dual requests: strict alternation, one accept every 3 cycles
        do_reset();
        exp_q.push_back('{id: 1'b0, y: 4'hA, err: 1'b0});
        exp_q.push_back('{id: 1'b1, y: 4'hC, err: 1'b0});
        exp_q.push_back('{id: 1'b0, y: 4'hA, err: 1'b0});
        exp_q.push_back('{id: 1'b1, y: 4'hC, err: 1'b0});
        drive(1'b0, 1'b1, 3'd2, 4'hF, 4'h5);
        drive(1'b1, 1'b1, 3'd4, 4'h3, 4'h0);
        n_acc = 0;
        last_cyc = 0;
        for (int cyc = 0; cyc < 40 && n_acc < 4; cyc++) begin
            @(negedge clk);
            if (bus.req0_ready || bus.req1_ready) begin
                chk("t2_grant_id", 32'(bus.req1_ready), 32'(n_acc % 2));
                if (n_acc > 0) chk("t2_interval", 32'(cyc - last_cyc), 32'd3);
                last_cyc = cyc;
                n_acc++;
            end
        end
        chk("t2_accepts", 32'(n_acc), 32'd4);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        wait_drain();

        // Backpressured NAND on req1 while req0 waits; req0 taken only after the handshake cycle
        bus.rsp_ready = 1'b0;
        issue(1'b1, 3'd3, 4'hF, 4'hF);
        drive(1'b0, 1'b1, 3'd1, 4'h3, 4'h4);
        n_acc = 0;
        for (int n = 0; n < 10 && n_acc == 0; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) n_acc = 1;
        end
        chk("t3_rsp_seen", 32'(n_acc), 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold_valid",  32'(bus.rsp_valid),  1);
            chk("t3_hold_y",      32'(bus.rsp_y),      0);
            chk("t3_hold_id",     32'(bus.rsp_id),     1);
            chk("t3_hold_ready0", 32'(bus.req0_ready), 0);
            chk("t3_hold_ready1", 32'(bus.req1_ready), 0);
            @(negedge clk);
        end
        @(posedge clk); #1 bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("t3_hs_ready0", 32'(bus.req0_ready), 0);
        @(negedge clk);
        chk("t3_after_rsp_valid", 32'(bus.rsp_valid),  0);
        chk("t3_after_ready0",    32'(bus.req0_ready), 1);
        if (bus.req0_ready) exp_q.push_back('{id: 1'b0, y: 4'h7, err: 1'b0});
        @(posedge clk); #1 bus.req0_valid = 1'b0;
        wait_drain();

        // Illegal opcodes
        issue(1'b0, 3'd6, 4'h5, 4'h5);
        issue(1'b1, 3'd7, 4'hA, 4'h3);
        wait_drain();

        // Reset during EXEC discards the op; then req0 wins the tie
        do_reset();
        drive(1'b0, 1'b1, 3'd0, 4'hF, 4'hF);
        @(negedge clk);
        chk("t5_ready0", 32'(bus.req0_ready), 1);
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("t5_rst_rsp_valid", 32'(bus.rsp_valid), 0);
        chk("t5_rst_busy",      32'(bus.busy),      0);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 3'd1, 4'hA, 4'h5);
        drive(1'b1, 1'b1, 3'd2, 4'hA, 4'h5);
        @(negedge clk);
        chk("t5_tie_ready0", 32'(bus.req0_ready), 1);
        chk("t5_tie_ready1", 32'(bus.req1_ready), 0);
        if (bus.req0_ready) exp_q.push_back('{id: 1'b0, y: 4'hF, err: 1'b0});
        @(posedge clk); #1 bus.req0_valid = 1'b0;
        issue(1'b1, 3'd2, 4'hA, 4'h5);
        wait_drain();

        // Exhaustive legal opcodes through req1
        for (int op = 0; op < 5; op++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    issue(1'b1, 3'(op), 4'(a), 4'(b));
                end
            end
        end
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule

// File: doc/logic_unit_arbiter.md
Name: logic_unit_arbiter

Overview:
- Shares one WIDTH-bit bitwise logic unit between two requesters. The unit supports AND, OR, XOR, NAND and NOR.
- Each requester presents an opcode and two operands on a valid/ready handshake.
- The arbiter grants round-robin, computes the result in a dedicated cycle, and returns it on a single response channel with its own valid/ready handshake.
- Sits between the requesting control blocks and the shared gates datapath.

Parameters:
- WIDTH, 4, operand and result width in bits.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- req0_valid  input  1  requester 0 has a valid operation.
- req0_op  input  3  requester 0 opcode.
- req0_a  input  WIDTH  requester 0 operand a.
- req0_b  input  WIDTH  requester 0 operand b.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req1_valid  input  1  requester 1 has a valid operation.
- req1_op  input  3  requester 1 opcode.
- req1_a  input  WIDTH  requester 1 operand a.
- req1_b  input  WIDTH  requester 1 operand b.
- req1_ready  output  1  requester 1 operation accepted this cycle.
- rsp_valid  output  1  response valid.
- rsp_id  output  1  requester index that owns the response.
- rsp_y  output  WIDTH  result.
- rsp_err  output  1  illegal opcode flag.
- rsp_ready  input  1  response consumer accepts.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is synchronous and active-high; all registers update on the rising edge of clk.
- Reset values: state=IDLE, last_grant=1 (so requester 0 wins the first tie), rsp_valid=0, rsp_id=0, rsp_y=0, rsp_err=0, busy=0. Captured op/a/b/id registers are cleared to 0.
- Opcodes:
  - 0: AND, a&b
  - 1: OR, a|b
  - 2: XOR, a^b
  - 3: NAND, ~(a&b)
  - 4: NOR, ~(a|b)
  - 5-7: illegal; rsp_y=0 and rsp_err=1
- Arithmetic is purely bitwise at WIDTH bits. There is no carry and no sign handling.
- FSM IDLE:
  - reqN_ready is combinational: (state==IDLE) AND grant==N AND reqN_valid.
  - Only one requester valid: that requester is granted.
  - Both valid: the requester != last_grant is granted.
  - On acceptance: capture op, a, b and id; set last_grant=id; go to EXEC.
  - No request: stay in IDLE.
- FSM EXEC:
  - Evaluate the logic function on the captured operands.
  - Register rsp_y, rsp_err and rsp_id; set rsp_valid=1; go to RESP.
  - Both reqN_ready are 0.
- FSM RESP:
  - rsp_valid=1.
  - rsp_y, rsp_err and rsp_id hold stable until rsp_ready is sampled high.
  - On rsp_ready: clear rsp_valid and go to IDLE. rsp_y/rsp_id/rsp_err may keep their last value.
  - Both reqN_ready are 0.
- Latency:
  - Handshake at cycle T gives rsp_valid high from cycle T+2.
  - Minimum issue interval is 3 cycles: a new accept can occur in the cycle after rsp_valid&rsp_ready.
- Handshake rules:
  - A requester holds valid, op, a and b stable until it sees ready.
  - The arbiter never asserts ready to a requester whose valid is low.
  - Requester payload changes while not granted are ignored.
- Simultaneous events:
  - A request arriving in the same cycle the response handshakes is not accepted that cycle; it is accepted in the following IDLE cycle.
  - A request held continuously through RESP is guaranteed a grant on the next IDLE cycle if the other requester was granted last.
- Starvation: under continuous dual requests, grants strictly alternate 0,1,0,1...
- Reset mid-operation: the in-flight operation is discarded, no response is emitted, and the FSM returns to IDLE with last_grant=1.
- busy=1 in EXEC and RESP.

Test Plan:
- Reset, then req0: valid=1, op=0, a=4'hC, b=4'hA -> req0_ready=1 that cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_y=4'h8, rsp_err=0.
- Both requesters valid continuously: req0 op=2 a=4'hF b=4'h5; req1 op=4 a=4'h3 b=4'h0; rsp_ready=1 -> responses alternate id 0 (y=4'hA), id 1 (y=4'hC), id 0, ...; one accept every 3 cycles.
- req1 op=3 a=4'hF b=4'hF with rsp_ready=0 for 5 cycles -> rsp_valid held, rsp_y=4'h0, rsp_id=1 stable; both readys=0; the cycle after rsp_ready=1, rsp_valid=0.
- req0 op=6 a=4'h5 b=4'h5 -> rsp_err=1, rsp_y=0.
- Accept req0, assert reset in EXEC -> next cycle rsp_valid=0, busy=0. With both requests then valid, req0 is granted first.
- Exhaustive check: all 5 legal opcodes against all 256 a/b pairs via req1 -> every rsp_y matches the bitwise reference model.
